// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared FP32 encodings, rounding modes and flag indices.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Internal exponent is two bits wider than the field so it can hold
    // both post-round overflow (up to 257) and negative underflow values.
    localparam int XEXP_W  = 10;

    localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF    = 32'h7F80_0000;
    localparam logic [31:0] FP32_MAXFIN = 32'h7F7F_FFFF;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module : fp_round_pack
// Brief  : Rounds a normalised significand and packs a binary32 result/flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_pkg::*;
(
    input  logic [31:0]        mant_i,
    input  logic [XEXP_W-1:0]  exp_i,
    input  logic               zero_i,
    input  logic               sign_i,
    input  logic               eff_sub_i,
    input  logic [2:0]         rm_i,
    output logic [31:0]        result_o,
    output logic [2:0]         flags_o
);

    logic              w_g;
    logic              w_s;
    logic              w_l;
    logic              w_up;
    logic              w_inf;
    logic              w_of;
    logic              w_uf;
    logic [24:0]       w_sig;
    logic [XEXP_W-1:0] w_exp;

    always_comb begin
        w_g = mant_i[7];
        w_s = |mant_i[6:0];
        w_l = mant_i[8];

        case (rm_i)
            RM_RNE:  w_up = w_g & (w_s | w_l);
            RM_RDN:  w_up = sign_i & (w_g | w_s);
            RM_RUP:  w_up = !sign_i & (w_g | w_s);
            RM_RMM:  w_up = w_g;
            default: w_up = 1'b0;
        endcase

        // With the hidden bit at mant_i[31], sig[24:23] is 1 normally and 2
        // after a rounding carry, so it doubles as the exponent adjustment.
        w_sig = {1'b0, mant_i[31:8]} + {24'd0, w_up};
        w_exp = exp_i - XEXP_W'(1) + {{(XEXP_W-2){1'b0}}, w_sig[24:23]};

        w_of  = !w_exp[XEXP_W-1] && (w_exp >= XEXP_W'(EXP_MAX));
        w_uf  = w_exp[XEXP_W-1] || (w_exp == '0);
        w_inf = (rm_i == RM_RNE) || (rm_i == RM_RMM) ||
                ((rm_i == RM_RUP) && !sign_i) ||
                ((rm_i == RM_RDN) && sign_i);

        result_o         = {sign_i, w_exp[7:0], w_sig[22:0]};
        flags_o          = '0;
        flags_o[FLAG_NX] = w_g | w_s;

        if (zero_i) begin
            result_o = {(eff_sub_i ? (rm_i == RM_RDN) : sign_i), 31'd0};
            flags_o  = '0;
        end else if (w_of) begin
            result_o         = w_inf ? {sign_i, FP32_INF[30:0]}
                                     : {sign_i, FP32_MAXFIN[30:0]};
            flags_o          = '0;
            flags_o[FLAG_OF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
        end else if (w_uf) begin
            result_o         = {sign_i, 31'd0};
            flags_o          = '0;
            flags_o[FLAG_UF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_norm_round.sv
// ============================================================================
// Module : fp_norm_round
// Brief  : Two-stage FP32 normalise (LZA shift + correction) and round/pack.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MANT_W = 32,
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic                    in_eff_sub,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic [4:0]              in_lz,
    input  logic [2:0]              in_rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic [2:0]              out_flags
);

    logic [MANT_W-1:0]    w_m0;
    logic [MANT_W-1:0]    w_m;
    logic                 w_fix;
    logic [5:0]           w_shift;
    logic [XEXP_W-1:0]    w_e;
    logic                 w_zero;
    logic                 w_s1_advance;
    logic                 w_s1_load;
    logic [31:0]          w_result;
    logic [2:0]           w_flags;

    logic                 s1_valid_q, s1_valid_d;
    logic [MANT_W-1:0]    s1_m_q;
    logic [XEXP_W-1:0]    s1_e_q;
    logic                 s1_zero_q;
    logic                 s1_sign_q;
    logic                 s1_eff_sub_q;
    logic [2:0]           s1_rm_q;

    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_result_q;
    logic [2:0]           s2_flags_q;

    assign w_s1_advance = !s2_valid_q || out_ready;
    assign in_ready     = !s1_valid_q || w_s1_advance;
    assign w_s1_load    = in_valid && in_ready;
    assign s1_valid_d   = in_ready ? in_valid : s1_valid_q;
    assign s2_valid_d   = w_s1_advance ? s1_valid_q : s2_valid_q;

    // The predictor may undercount by one; a clear MSB after the shift
    // means one more position is needed.
    always_comb begin
        w_m0    = in_mant << in_lz;
        w_fix   = !w_m0[MANT_W-1] && (w_m0 != '0);
        w_m     = w_fix ? (w_m0 << 1) : w_m0;
        w_shift = {1'b0, in_lz} + {5'd0, w_fix};
        w_e     = {{(XEXP_W-EXP_W){1'b0}}, in_exp} + XEXP_W'(1)
                  - {{(XEXP_W-6){1'b0}}, w_shift};
        w_zero  = (in_mant == '0);
    end

    fp_round_pack u_round_pack (
        .mant_i    (s1_m_q),
        .exp_i     (s1_e_q),
        .zero_i    (s1_zero_q),
        .sign_i    (s1_sign_q),
        .eff_sub_i (s1_eff_sub_q),
        .rm_i      (s1_rm_q),
        .result_o  (w_result),
        .flags_o   (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_e_q       <= '0;
            s1_zero_q    <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_eff_sub_q <= 1'b0;
            s1_rm_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (w_s1_load) begin
                s1_m_q       <= w_m;
                s1_e_q       <= w_e;
                s1_zero_q    <= w_zero;
                s1_sign_q    <= in_sign;
                s1_eff_sub_q <= in_eff_sub;
                s1_rm_q      <= in_rm;
            end
            if (w_s1_advance && s1_valid_q) begin
                s2_result_q <= w_result;
                s2_flags_q  <= w_flags;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;

endmodule

`default_nettype wire

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Pipelined normalise-and-round stage of the FP32 adder, directly downstream of the leading-zero/one predictor.
- Consumes the raw 32-bit mantissa sum, the predicted shift count, sign and pre-normalisation exponent.
- Left-shifts by the prediction, applies the one-bit LZA correction, rounds per RISC-V rounding mode, and packs an IEEE-754 binary32 result with exception flags.
- Two register stages with valid/ready flow control.

Parameters:
MANT_W, 32, width of incoming mantissa sum; fixed at 32 for FP32.
EXP_W, 8, biased exponent width.
FRAC_W, 23, stored fraction width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  upstream word valid.
in_ready  out  1  stage can accept a word.
in_sign  in  1  result sign from effective-operation logic.
in_eff_sub  in  1  effective subtraction flag.
in_exp  in  EXP_W  biased exponent of larger operand.
in_mant  in  MANT_W  sum magnitude; value = in_mant * 2^(in_exp-127-30).
in_lz  in  5  predicted leading-zero count; true count is in_lz or in_lz+1.
in_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
out_result  out  32  packed binary32.
out_flags  out  3  {OF, UF, NX}.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: both stage valid bits cleared; out_valid=0, out_result=0, out_flags=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight words are discarded and no partial result is presented.
- Handshake:
  - A transfer occurs when valid&ready are both high.
  - in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
  - Outputs are held stable while out_valid & !out_ready.
  - No combinational path from in_valid to out_valid.
  - Full throughput: one word per cycle.
  - Latency is 2 cycles from input transfer to out_valid when not stalled.
- Stage 1 (normalise):
  - m = in_mant << in_lz.
  - If m[31]=0 and m!=0: m <<= 1 and s = in_lz+1; otherwise s = in_lz.
  - Exponent arithmetic is signed, 10 bits: e = in_exp + 1 - s.
  - zero = (in_mant == 0).
  - Registers m, e, zero, sign, rm and eff_sub.
- Stage 2 (round and pack):
  - Field extraction: frac = m[30:8], G = m[7], S = |m[6:0], L = m[8].
  - Round-up conditions:
    - RNE: G&(S|L).
    - RTZ: 0.
    - RDN: sign&(G|S).
    - RUP: !sign&(G|S).
    - RMM: G.
  - A rounding carry out of frac sets frac=0 and e=e+1.
  - NX = G|S.
  - Overflow (e >= 255 after rounding): OF=1, NX=1.
    - Result is ±inf for RNE/RMM, and for RUP when positive or RDN when negative.
    - Otherwise result is ±0x7F7FFFFF (max finite).
  - Underflow (e <= 0, non-zero): flush to signed zero; UF=1, NX=1. No subnormals are produced.
  - Exact zero (zero=1):
    - Result is +0, or -0 when rm=RDN and eff_sub=1.
    - When eff_sub=0, the result takes in_sign.
    - Flags are 0.
  - Normal result: {sign, e[7:0], frac}.
- in_lz values above 31 cannot occur (5-bit port). A shift that pushes the leading one out of m is impossible given the ±1 prediction guarantee; the verification engineer asserts that m[31]=1 after correction whenever zero=0.

Decomposition:
- Package fp_pkg holds:
  - the rounding-mode enum (RNE..RMM);
  - FP32 constants BIAS=127, EXP_MAX=255, QNAN/INF/MAXFIN encodings;
  - the flag-bit index constants.
- One sub-module, fp_round_pack: stage-2 combinational rounding, overflow/underflow and packing logic. This keeps the pipeline/handshake wrapper separate and lets the module be reused by the multiplier.

Test Plan:
- 1.0 exact: in_mant=0x40000000, in_exp=127, in_lz=1, RNE -> out_result=0x3F800000, flags=000, out_valid 2 cycles after transfer.
- Carry position: in_mant=0x80000000, in_exp=127, in_lz=0 -> 0x40000000 (2.0), flags=000.
- LZA correction: in_mant=0x20000000, in_exp=127, in_lz=1 -> extra shift applied, 0x3F000000 (0.5), flags=000.
- RNE tie-to-even:
  - in_mant=0x400000C0, in_exp=127, in_lz=1 -> 0x3F800002, NX=1.
  - Same input with RTZ -> 0x3F800001.
- Overflow: in_mant=0x80000000, in_exp=254, in_lz=0:
  - RNE -> 0x7F800000, flags=101.
  - RTZ -> 0x7F7FFFFF, flags=101.
- Backpressure and reset:
  - Stream 4 words with out_ready low for 3 cycles -> in_ready drops after 2 accepted, out_result stable, order preserved, no loss.
  - Exact zero, eff_sub=1, RDN -> 0x80000000.
  - Assert rst with 2 words in flight -> out_valid=0 next cycle and no stale result afterwards.
